// File: rtl/id_stage_hz.sv
// LEGv8 decode stage: register file, main decoder, immediates, early branch
// resolution, load-use / branch-operand hazard detection and the ID/EX register.
module id_stage_hz #(
  parameter int DATA_W = 64,
  parameter int NREG   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              exmem_reg_write,
  input  logic              exmem_mem_read,
  input  logic [4:0]        exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  output logic              stall_if,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              idex_valid,
  output logic              idex_reg_write,
  output logic              idex_mem_read,
  output logic              idex_mem_write,
  output logic              idex_mem_to_reg,
  output logic              idex_alu_src,
  output logic              idex_link,
  output logic              idex_illegal,
  output logic [1:0]        idex_alu_op,
  output logic [4:0]        idex_rn,
  output logic [4:0]        idex_rm,
  output logic [4:0]        idex_rd,
  output logic [DATA_W-1:0] idex_rn_data,
  output logic [DATA_W-1:0] idex_rm_data,
  output logic [DATA_W-1:0] idex_imm,
  output logic [DATA_W-1:0] idex_pc
);

  typedef enum logic [3:0] {
    C_ILL, C_ADD, C_SUB, C_AND, C_ORR, C_ADDI, C_SUBI,
    C_LDUR, C_STUR, C_B, C_BL, C_CBZ, C_CBNZ, C_BR
  } iclass_t;

  localparam logic [5:0] NREG_L = 6'(NREG);
  localparam logic [4:0] XZR    = 5'd31;

  logic [DATA_W-1:0] regs [NREG];

  iclass_t           iclass;
  logic [10:0]       opcode;
  logic [4:0]        rn_idx, rm_idx, rd_idx, br_src;
  logic [DATA_W-1:0] rn_val, rm_val, imm, br_val;
  logic              is_rtype, is_itype, is_cb, uses_rn, uses_rm, makes_entry;
  logic              load_use, br_hazard, fwd_hit, stall, cond_taken;

  assign opcode = instruction[31:21];
  assign rn_idx = instruction[9:5];
  assign rd_idx = instruction[4:0];

  always_comb begin
    casez (opcode)
      11'b10001011000: iclass = C_ADD;
      11'b11001011000: iclass = C_SUB;
      11'b10001010000: iclass = C_AND;
      11'b10101010000: iclass = C_ORR;
      11'b1001000100?: iclass = C_ADDI;
      11'b1101000100?: iclass = C_SUBI;
      11'b11111000010: iclass = C_LDUR;
      11'b11111000000: iclass = C_STUR;
      11'b000101?????: iclass = C_B;
      11'b100101?????: iclass = C_BL;
      11'b10110100???: iclass = C_CBZ;
      11'b10110101???: iclass = C_CBNZ;
      11'b11010110000: iclass = C_BR;
      default:         iclass = C_ILL;
    endcase
  end

  assign is_rtype    = (iclass == C_ADD) || (iclass == C_SUB) || (iclass == C_AND) || (iclass == C_ORR);
  assign is_itype    = (iclass == C_ADDI) || (iclass == C_SUBI);
  assign is_cb       = (iclass == C_CBZ) || (iclass == C_CBNZ);
  assign uses_rn     = is_rtype || is_itype || (iclass == C_LDUR) || (iclass == C_STUR) || (iclass == C_BR);
  assign uses_rm     = is_rtype || (iclass == C_STUR);
  assign makes_entry = is_rtype || is_itype || (iclass == C_LDUR) || (iclass == C_STUR) || (iclass == C_BL);

  // The second read port serves Rt for stores and compare-branches.
  assign rm_idx = ((iclass == C_STUR) || is_cb) ? rd_idx : instruction[20:16];

  function automatic logic [DATA_W-1:0] read_port(input logic [4:0] idx);
    if (idx == XZR || {1'b0, idx} >= NREG_L) return '0;
    else if (wb_we && wb_rd == idx)          return wb_data;
    else                                     return regs[idx];
  endfunction

  assign rn_val = read_port(rn_idx);
  assign rm_val = read_port(rm_idx);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we && wb_rd != XZR && {1'b0, wb_rd} < NREG_L) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    imm = '0;
    case (iclass)
      C_ADDI, C_SUBI: imm = {{(DATA_W-12){1'b0}}, instruction[21:10]};
      C_LDUR, C_STUR: imm = {{(DATA_W-9){instruction[20]}}, instruction[20:12]};
      C_B, C_BL:      imm = {{(DATA_W-28){instruction[25]}}, instruction[25:0], 2'b00};
      C_CBZ, C_CBNZ:  imm = {{(DATA_W-21){instruction[23]}}, instruction[23:5], 2'b00};
      default:        imm = '0;
    endcase
  end

  // XZR is never forwarded: a write to X31 in MEM still reads as zero here.
  assign br_src  = (iclass == C_BR) ? rn_idx : rd_idx;
  assign fwd_hit = FWD_EN && exmem_reg_write && !exmem_mem_read &&
                   (exmem_rd == br_src) && (br_src != XZR);
  assign br_val  = fwd_hit ? exmem_data : ((iclass == C_BR) ? rn_val : rm_val);

  assign load_use = idex_valid && idex_mem_read && (idex_rd != XZR) &&
                    ((uses_rn && idex_rd == rn_idx) || (uses_rm && idex_rd == rm_idx));

  assign br_hazard = (is_cb || iclass == C_BR) && (br_src != XZR) &&
                     ((idex_valid && idex_reg_write && idex_rd == br_src) ||
                      (exmem_reg_write && exmem_rd == br_src && (exmem_mem_read || !FWD_EN)));

  assign stall = if_valid && (load_use || br_hazard);

  always_comb begin
    cond_taken = 1'b0;
    case (iclass)
      C_B, C_BL, C_BR: cond_taken = 1'b1;
      C_CBZ:           cond_taken = (br_val == '0);
      C_CBNZ:          cond_taken = (br_val != '0);
      default:         cond_taken = 1'b0;
    endcase
  end

  assign stall_if      = stall;
  assign branch_taken  = if_valid && !stall && cond_taken;
  assign branch_target = (iclass == C_BR) ? br_val : pc_in + imm;

  // Every cycle defaults to a bubble; only a decodable, unstalled instruction
  // that produces work for EX overrides it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idex_valid      <= 1'b0;
      idex_reg_write  <= 1'b0;
      idex_mem_read   <= 1'b0;
      idex_mem_write  <= 1'b0;
      idex_mem_to_reg <= 1'b0;
      idex_alu_src    <= 1'b0;
      idex_link       <= 1'b0;
      idex_illegal    <= 1'b0;
      idex_alu_op     <= 2'b00;
      idex_rn         <= '0;
      idex_rm         <= '0;
      idex_rd         <= '0;
      idex_rn_data    <= '0;
      idex_rm_data    <= '0;
      idex_imm        <= '0;
      idex_pc         <= '0;
    end else begin
      idex_valid      <= 1'b0;
      idex_reg_write  <= 1'b0;
      idex_mem_read   <= 1'b0;
      idex_mem_write  <= 1'b0;
      idex_mem_to_reg <= 1'b0;
      idex_alu_src    <= 1'b0;
      idex_link       <= 1'b0;
      idex_illegal    <= 1'b0;
      idex_alu_op     <= 2'b00;
      idex_rn         <= '0;
      idex_rm         <= '0;
      idex_rd         <= '0;
      idex_rn_data    <= '0;
      idex_rm_data    <= '0;
      idex_imm        <= '0;
      idex_pc         <= '0;
      if (if_valid && !stall) begin
        if (iclass == C_ILL) begin
          idex_illegal <= 1'b1;
        end else if (makes_entry) begin
          idex_valid      <= 1'b1;
          idex_reg_write  <= (iclass != C_STUR);
          idex_mem_read   <= (iclass == C_LDUR);
          idex_mem_write  <= (iclass == C_STUR);
          idex_mem_to_reg <= (iclass == C_LDUR);
          idex_alu_src    <= is_itype || (iclass == C_LDUR) || (iclass == C_STUR);
          idex_link       <= (iclass == C_BL);
          idex_alu_op     <= is_rtype ? 2'b10 : ((iclass == C_SUBI) ? 2'b01 : 2'b00);
          idex_rn         <= rn_idx;
          idex_rm         <= rm_idx;
          idex_rd         <= (iclass == C_BL) ? 5'd30 : rd_idx;
          idex_rn_data    <= rn_val;
          idex_rm_data    <= rm_val;
          idex_imm        <= imm;
          idex_pc         <= pc_in;
        end
      end
    end
  end

endmodule

// File: doc/id_stage_hz.md
Name: id_stage_hz

Overview:
- Parametrised successor to the single-cycle-control decode stage of the pipelined ARMv8 (LEGv8 subset) core.
- Sits between the IF/ID register and EX. Contains the register file, main decoder, immediate generation and early branch resolution (B, BL, CBZ, CBNZ, BR) in ID.
- Adds load-use and branch-operand hazard detection, EX/MEM forwarding for branch operands, and an internal ID/EX pipeline register.

Parameters:
- DATA_W, 64, datapath/register width in bits.
- NREG, 32, architectural registers implemented (≤32). Indices ≥NREG read 0 and ignore writes. Index 31 is always XZR.
- FWD_EN, 1, 1 = forward EX/MEM ALU result to branch operands; 0 = stall until WB instead.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- if_valid  in  1  IF/ID holds a valid instruction
- instruction  in  32  IF/ID instruction
- pc_in  in  DATA_W  PC of that instruction
- wb_we  in  1  WB register write enable
- wb_rd  in  5  WB destination register
- wb_data  in  DATA_W  WB write data
- exmem_reg_write  in  1  instruction in MEM writes a register
- exmem_mem_read  in  1  instruction in MEM is a load
- exmem_rd  in  5  MEM destination register
- exmem_data  in  DATA_W  MEM-stage ALU result
- stall_if  out  1  hold PC and IF/ID this cycle
- branch_taken  out  1  redirect fetch; also flushes IF/ID
- branch_target  out  DATA_W  redirect address
- idex_valid, idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg, idex_alu_src, idex_link, idex_illegal  out  1 each  registered controls
- idex_alu_op  out  2  00 add, 01 sub, 10 R-type funct
- idex_rn, idex_rm, idex_rd  out  5 each  registered register indices
- idex_rn_data, idex_rm_data, idex_imm, idex_pc  out  DATA_W each  registered operands, immediate and PC

Behaviour:
- Reset (async): all registers and every idex_* output go to 0. Combinational outputs follow from idex_valid=0.
- Register file:
  - Writes on the clock edge when wb_we and wb_rd≠31.
  - Reads are combinational.
  - Write-through: a read of wb_rd while wb_we is asserted returns wb_data.
  - X31 reads 0.
- Decode on instruction[31:21]:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - ADDI 1001000100x, SUBI 1101000100x.
  - LDUR 11111000010, STUR 11111000000.
  - B 000101xxxxx, BL 100101xxxxx.
  - CBZ 10110100xxx, CBNZ 10110101xxx.
  - BR 11010110000.
  - Any other opcode: bubble with idex_illegal=1.
- Second read port: Rt[4:0] for STUR/CBZ/CBNZ, Rm[20:16] otherwise.
- Immediates:
  - D-type: sext [20:12].
  - I-type: zext [21:10].
  - B/BL: sext [25:0]<<2.
  - CB: sext [23:5]<<2.
  - Sign extension is to DATA_W.
- Branch target:
  - pc_in + offset, modulo 2^DATA_W.
  - BR: Rn value.
- Taken condition:
  - B, BL: always.
  - CBZ: operand == 0.
  - CBNZ: operand ≠ 0.
  - branch_taken is asserted only when if_valid and not stalled.
- BL: ID/EX receives idex_rd=30, idex_reg_write=1, idex_link=1, idex_pc=pc_in. EX writes pc+4.
- Load-use stall: asserted when idex_valid & idex_mem_read & idex_rd≠31 & idex_rd matches a used source (Rn, or the second port for R-type and STUR).
- Branch-operand stall (CBZ/CBNZ Rt, BR Rn). Asserted when the source ≠31 and any of these hold:
  - (a) idex_valid & idex_reg_write & idex_rd==src;
  - (b) exmem_reg_write & exmem_rd==src & (exmem_mem_read | FWD_EN==0).
- Forwarding: when FWD_EN=1, exmem_reg_write, not a load, and exmem_rd==src, the branch operand uses exmem_data. Forwarding has priority over the register file.
- On stall:
  - stall_if=1.
  - The next ID/EX loads a bubble: all controls 0, idex_valid=0.
  - The instruction is re-decoded the next cycle.
- On branch_taken:
  - The branch's own ID/EX entry is loaded normally (valid only for BL; otherwise a bubble).
  - IF/ID is flushed externally.
- When if_valid=0: bubble.
- Latency: decode to ID/EX is 1 cycle. A load-to-dependent stall lasts 1 cycle. A load-to-branch stall lasts 2 cycles.

Test Plan:
- Reset asserted mid-stream with the ID/EX holding LDUR → all idex_* =0 immediately, without waiting for a clock edge; X1 reads 0 after reset.
- WB writes X2=0x55 while ADD X3,X2,X2 is in ID → idex_rn_data=idex_rm_data=0x55 on the next edge (write-through).
- LDUR X1,[X2,#8] followed by ADD X4,X1,X5 → stall_if=1 for exactly 1 cycle, one bubble, then ADD enters ID/EX with idex_rn=1.
- SUB X6,X7,X7 followed by CBZ X6,#+16 with pc_in=0x100 → 1 stall cycle; then, with forwarding of exmem_data=0: branch_taken=1, branch_target=0x140.
- Same sequence with FWD_EN=0 → 2 stall cycles, then taken via the WB write-through path.
- BL #-4 at pc_in=0x200 → branch_taken=1, branch_target=0x1F0; ID/EX: idex_link=1, idex_rd=30, idex_pc=0x200.
- Opcode 0x000 → idex_illegal=1, idex_valid=0, branch_taken=0.
